aexm_refill_arbiter: RTL

- Shares one external memory burst port between icache line refills and dcache line refills/writebacks.
- Sits between the two cache controllers and the system memory bus, below the CPU core.
- Grants one requester at a time, issues one burst command, counts LINE_WORDS data beats, then signals completion.
- Fairness is round-robin across back-to-back contention.

---
 rtl/aexm_refill_pkg.sv | 30 +++
 rtl/aexm_rr_arb2.sv | 47 ++++
 rtl/aexm_refill_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/aexm_refill_pkg.sv
// ---------------------------------------------------------------------------
// aexm_refill_pkg
// Shared definitions for the cache refill arbiter slice:
//   - burst FSM state encoding (3-bit) and the enum built on it
//   - owner encoding for the two requesting caches
//   - default line geometry (beats per burst and its log2)
// ---------------------------------------------------------------------------
package aexm_refill_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_RBURST = 3'd2;
    localparam logic [2:0] ST_WBURST = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        CMD    = ST_CMD,
        RBURST = ST_RBURST,
        WBURST = ST_WBURST,
        DONE   = ST_DONE
    } burstState_t;

    localparam logic OWNER_IC = 1'b0;
    localparam logic OWNER_DC = 1'b1;

    localparam int LINE_WORDS_DEF = 8;
    localparam int LW_DEF         = 3;

endpackage

// File: rtl/aexm_rr_arb2.sv
// ---------------------------------------------------------------------------
// aexm_rr_arb2
// Two-way round-robin pick between the icache and dcache requests.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   icReq, dcReq : request lines from the two caches
//   enable       : arbitration is allowed this cycle (burst port free)
//   grant        : a request is being granted this cycle
//   owner        : which requester wins (OWNER_IC / OWNER_DC)
// ---------------------------------------------------------------------------
module aexm_rr_arb2
    import aexm_refill_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic icReq,
    input  logic dcReq,
    input  logic enable,
    output logic grant,
    output logic owner
);

    logic last;

    // Under contention the requester that was not served last wins, so a
    // cache that keeps re-requesting cannot starve the other one.
    always_comb begin
        owner = OWNER_IC;
        if (icReq && dcReq) begin
            owner = ~last;
        end else if (dcReq) begin
            owner = OWNER_DC;
        end
        grant = enable && (icReq || dcReq);
    end

    // Remember who was granted most recently. Reset to icache so the first
    // contention after reset goes to dcache.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last <= OWNER_IC;
        end else if (grant) begin
            last <= owner;
        end
    end

endmodule

// File: rtl/aexm_refill_arbiter.sv
// ---------------------------------------------------------------------------
// aexm_refill_arbiter
// Shares one external memory burst port between icache refills and dcache
// refills/writebacks. One requester owns the port at a time; a burst is one
// command followed by LINE_WORDS data beats, then a one-cycle done pulse.
// Ports:
//   sys_clk_i / sys_rst_i       : clock, asynchronous active-high reset
//   ic_*                        : icache request/address, grant, read valid, done
//   dc_*                        : dcache request/dir/address/wdata, grant,
//                                 read valid, write-beat advance, done
//   rdata_o                     : read beat data, broadcast to both caches
//   mem_cmd_* / mem_addr_o / mem_we_o : burst command channel
//   mem_rvalid_i / mem_rdata_i  : read beat channel
//   mem_wvalid_o / mem_wready_i / mem_wdata_o : write beat channel
// ---------------------------------------------------------------------------
module aexm_refill_arbiter
    import aexm_refill_pkg::*;
#(
    parameter int AW         = 32,
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int LW         = LW_DEF
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,
    input  logic          ic_req_i,
    input  logic [AW-1:0] ic_addr_i,
    output logic          ic_gnt_o,
    output logic          ic_valid_o,
    output logic          ic_done_o,
    input  logic          dc_req_i,
    input  logic          dc_we_i,
    input  logic [AW-1:0] dc_addr_i,
    input  logic [31:0]   dc_wdata_i,
    output logic          dc_gnt_o,
    output logic          dc_valid_o,
    output logic          dc_wnext_o,
    output logic          dc_done_o,
    output logic [31:0]   rdata_o,
    output logic          mem_cmd_valid_o,
    input  logic          mem_cmd_ready_i,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_we_o,
    input  logic          mem_rvalid_i,
    input  logic [31:0]   mem_rdata_i,
    output logic          mem_wvalid_o,
    input  logic          mem_wready_i,
    output logic [31:0]   mem_wdata_o
);

    // Clears the word-in-line and byte-in-word bits of a miss address.
    localparam logic [AW-1:0] LINE_MASK = {AW{1'b1}} << (LW + 2);

    burstState_t   state, nextState;
    logic          owner;
    logic          we;
    logic [AW-1:0] lineAddr;
    logic [LW-1:0] beatCount;
    logic [31:0]   rdataHold;
    logic          arbGrant;
    logic          arbOwner;
    logic          beat;
    logic          lastBeat;
    logic          readBeat;

    // Arbitration only happens while the port is idle; the DONE cycle always
    // passes through IDLE, which enforces the one-cycle gap between bursts.
    aexm_rr_arb2 uArb (
        .clock  (sys_clk_i),
        .reset  (sys_rst_i),
        .icReq  (ic_req_i),
        .dcReq  (dc_req_i),
        .enable (state == IDLE),
        .grant  (arbGrant),
        .owner  (arbOwner)
    );

    assign readBeat = (state == RBURST) && mem_rvalid_i;
    assign beat     = readBeat || ((state == WBURST) && mem_wready_i);
    assign lastBeat = (beatCount == LW'(LINE_WORDS - 1));

    // Burst FSM state register.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Burst FSM next-state logic. A dropped request never aborts a burst;
    // once granted the FSM always runs through DONE.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (arbGrant) nextState = CMD;
            CMD:     if (mem_cmd_ready_i) nextState = we ? WBURST : RBURST;
            RBURST,
            WBURST:  if (beat && lastBeat) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Per-burst context captured at grant time, the beat counter and the
    // held copy of the last read beat. Direction is only taken from dcache;
    // icache bursts are always reads.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            owner     <= OWNER_IC;
            we        <= 1'b0;
            lineAddr  <= '0;
            beatCount <= '0;
            rdataHold <= '0;
        end else begin
            if ((state == IDLE) && arbGrant) begin
                owner    <= arbOwner;
                we       <= (arbOwner == OWNER_DC) ? dc_we_i : 1'b0;
                lineAddr <= ((arbOwner == OWNER_DC) ? dc_addr_i : ic_addr_i) & LINE_MASK;
            end
            if ((state == CMD) && mem_cmd_ready_i) begin
                beatCount <= '0;
            end else if (beat) begin
                beatCount <= beatCount + LW'(1);
            end
            if (readBeat) begin
                rdataHold <= mem_rdata_i;
            end
        end
    end

    // Outputs decode directly from flopped state/owner, so grants, done and
    // the command channel are glitch-free and clear with reset. Read data is
    // passed through on a valid beat and otherwise holds the last beat.
    always_comb begin
        ic_gnt_o        = (state != IDLE) && (owner == OWNER_IC);
        dc_gnt_o        = (state != IDLE) && (owner == OWNER_DC);
        ic_done_o       = (state == DONE) && (owner == OWNER_IC);
        dc_done_o       = (state == DONE) && (owner == OWNER_DC);
        ic_valid_o      = readBeat && (owner == OWNER_IC);
        dc_valid_o      = readBeat && (owner == OWNER_DC);
        rdata_o         = readBeat ? mem_rdata_i : rdataHold;
        mem_cmd_valid_o = (state == CMD);
        mem_addr_o      = lineAddr;
        mem_we_o        = we;
        mem_wvalid_o    = (state == WBURST);
        mem_wdata_o     = dc_wdata_i;
        dc_wnext_o      = (state == WBURST) && mem_wready_i;
    end

endmodule
